// File: rtl/b_uart.sv
// b_uart: 8N1 full-duplex UART with fractional phase-accumulator baud timing
module b_uart #(
    parameter int unsigned CLKFREQ = 1000000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] baud,
    input  logic        rx,
    output logic        tx,
    input  logic        rd,
    input  logic        wr,
    output logic        valid,
    output logic        busy,
    input  logic [7:0]  tx_data,
    output logic [7:0]  rx_data
);
    localparam logic [32:0] FREQ = 33'(CLKFREQ);
    localparam logic [32:0] HALF = 33'(CLKFREQ / 2);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;
    tx_state_t   r_tx_state, w_tx_next;
    logic [32:0] r_tx_acc;
    logic [32:0] w_tx_sum;
    logic        w_tx_tick;
    logic        w_tx_go;
    logic [7:0]  r_tx_shr;
    logic [2:0]  r_tx_cnt;
    rx_state_t   r_rx_state, w_rx_next;
    logic [32:0] r_rx_acc;
    logic [32:0] w_rx_sum;
    logic        w_rx_tick;
    logic [2:0]  r_rx_sync;
    logic        w_rx_line;
    logic        w_rx_fall;
    logic        w_rx_done;
    logic [7:0]  r_rx_shr;
    logic [2:0]  r_rx_cnt;
    logic [7:0]  r_rx_data;
    logic        r_valid;

    assign w_tx_sum  = r_tx_acc + {1'b0, baud};
    assign w_tx_tick = w_tx_sum >= FREQ;
    assign w_tx_go   = (r_tx_state == TX_IDLE) && wr;
    assign busy      = r_tx_state != TX_IDLE;

    // TX state register
    always_ff @(posedge clk or posedge resetq)
        if (resetq) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;

    // TX next state and serial line: start bit low, data LSB first, stop/idle high
    always_comb begin
        w_tx_next = r_tx_state;
        tx        = 1'b1;
        case (r_tx_state)
            TX_IDLE:  w_tx_next = wr ? TX_START : TX_IDLE;
            TX_START: begin
                tx        = 1'b0;
                w_tx_next = w_tx_tick ? TX_DATA : TX_START;
            end
            TX_DATA: begin
                tx        = r_tx_shr[0];
                w_tx_next = (w_tx_tick && r_tx_cnt == 3'd7) ? TX_STOP : TX_DATA;
            end
            TX_STOP:  w_tx_next = w_tx_tick ? TX_IDLE : TX_STOP;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    // TX bit timing restarts at each accepted write so the start bit is a full period
    always_ff @(posedge clk or posedge resetq)
        if (resetq) begin
            r_tx_acc <= '0;
            r_tx_shr <= '0;
            r_tx_cnt <= '0;
        end else begin
            r_tx_acc <= w_tx_go ? '0 : (w_tx_tick ? w_tx_sum - FREQ : w_tx_sum);
            if (w_tx_go) begin
                r_tx_shr <= tx_data;
                r_tx_cnt <= '0;
            end else if (r_tx_state == TX_DATA && w_tx_tick) begin
                r_tx_shr <= r_tx_shr >> 1;
                r_tx_cnt <= r_tx_cnt + 3'd1;
            end
        end

    assign w_rx_line = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];
    assign w_rx_sum  = r_rx_acc + {1'b0, baud};
    assign w_rx_tick = w_rx_sum >= FREQ;
    assign rx_data   = r_rx_data;
    assign valid     = r_valid;

    // RX two-flop synchronizer plus one history bit for edge detection
    always_ff @(posedge clk or posedge resetq)
        if (resetq) r_rx_sync <= 3'b111;
        else        r_rx_sync <= {r_rx_sync[1:0], rx};

    // RX state register
    always_ff @(posedge clk or posedge resetq)
        if (resetq) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;

    // RX next state; a low stop bit parks in WAITHI so the tail cannot fake a start
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_done = 1'b0;
        case (r_rx_state)
            RX_IDLE:   w_rx_next = w_rx_fall ? RX_START : RX_IDLE;
            RX_START:  if (w_rx_tick) w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_tick && r_rx_cnt == 3'd7) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_next = w_rx_line ? RX_IDLE : RX_WAITHI;
                    w_rx_done = w_rx_line;
                end
            end
            RX_WAITHI: w_rx_next = w_rx_line ? RX_IDLE : RX_WAITHI;
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: half-period preset puts every tick mid-bit; completion beats rd
    always_ff @(posedge clk or posedge resetq)
        if (resetq) begin
            r_rx_acc  <= '0;
            r_rx_shr  <= '0;
            r_rx_cnt  <= '0;
            r_rx_data <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_rx_acc <= (r_rx_state == RX_IDLE && w_rx_fall) ? HALF :
                        (w_rx_tick ? w_rx_sum - FREQ : w_rx_sum);
            if (r_rx_state == RX_IDLE)
                r_rx_cnt <= '0;
            else if (r_rx_state == RX_DATA && w_rx_tick) begin
                r_rx_shr <= {w_rx_line, r_rx_shr[7:1]};
                r_rx_cnt <= r_rx_cnt + 3'd1;
            end
            if (w_rx_done) r_rx_data <= r_rx_shr;
            r_valid <= w_rx_done | (r_valid & ~rd);
        end
endmodule

// File: tb/tb_b_uart.sv
// tb_b_uart: directed self-checking bench for b_uart at 10 clk per bit
module tb_b_uart;
    logic        clk = 1'b0;
    logic        resetq;
    logic [31:0] baud;
    logic        rx_drv;
    logic        loop;
    logic        rx_in;
    logic        tx;
    logic        rd;
    logic        wr;
    logic        valid;
    logic        busy;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;
    int          checks = 0;
    int          errors = 0;
    int          rise;
    int          n;
    logic [9:0]  fr;

    assign rx_in = loop ? tx : rx_drv;

    b_uart #(.CLKFREQ(1000000)) dut (
        .clk(clk), .resetq(resetq), .baud(baud), .rx(rx_in), .tx(tx),
        .rd(rd), .wr(wr), .valid(valid), .busy(busy),
        .tx_data(tx_data), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop, input int rd_lo,
                            input int rd_hi, output int first);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        first = -1;
        for (int i = 0; i < 100; i++) begin
            rx_drv = f[i/10];
            rd = (i >= rd_lo && i <= rd_hi);
            step();
            if (first < 0 && valid) first = i;
        end
        rd = 1'b0;
    endtask

    initial begin
        resetq = 1'b1; baud = 32'd100000; rx_drv = 1'b1; loop = 1'b0;
        rd = 1'b0; wr = 1'b0; tx_data = 8'h00;
        repeat (3) step();
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_valid", valid, 0);
        chk("reset_rx_data", rx_data, 8'h00);
        resetq = 1'b0;
        repeat (3) step();
        // transmit 0x55 with an ignored write in mid-frame
        wr = 1'b1; tx_data = 8'h55;
        step();
        fr = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c <= 100; c++) begin
            if (c % 10 == 5) chk($sformatf("tx_bit%0d", c / 10), tx, fr[c/10]);
            if (c == 0 || c == 99) chk($sformatf("tx_busy_c%0d", c), busy, 1);
            if (c == 100) chk("tx_busy_end", busy, 0);
            wr = (c == 50);
            tx_data = (c == 50) ? 8'hFF : 8'h55;
            step();
        end
        wr = 1'b0;
        repeat (20) step();
        chk("tx_no_second_frame", busy, 0);
        chk("tx_idle_high", tx, 1);
        // receive 0xA5 and acknowledge
        rx_frame(8'hA5, 1'b1, -1, -1, rise);
        chk("rx_latency_ok", (rise >= 94 && rise <= 99), 1);
        chk("rx_a5_valid", valid, 1);
        chk("rx_a5_data", rx_data, 8'hA5);
        rd = 1'b1; step(); rd = 1'b0;
        chk("rd_clears_valid", valid, 0);
        rd = 1'b1; step(); rd = 1'b0;
        chk("rd_idle_valid", valid, 0);
        chk("rd_idle_data", rx_data, 8'hA5);
        // short glitch must not produce a byte
        rx_drv = 1'b0; repeat (3) step(); rx_drv = 1'b1;
        repeat (20) step();
        chk("glitch_no_valid", valid, 0);
        rx_frame(8'h3C, 1'b1, -1, -1, rise);
        chk("after_glitch_valid", valid, 1);
        chk("after_glitch_data", rx_data, 8'h3C);
        rd = 1'b1; step(); rd = 1'b0;
        // framing error: byte discarded, line held low afterwards
        rx_frame(8'hF0, 1'b0, -1, -1, rise);
        repeat (30) step();
        chk("frame_err_valid", valid, 0);
        chk("frame_err_data", rx_data, 8'h3C);
        rx_drv = 1'b1; repeat (10) step();
        rx_frame(8'h81, 1'b1, -1, -1, rise);
        chk("after_ferr_valid", valid, 1);
        chk("after_ferr_data", rx_data, 8'h81);
        rd = 1'b1; step(); rd = 1'b0;
        // overrun overwrites, valid stays set
        rx_frame(8'h11, 1'b1, -1, -1, rise);
        rx_frame(8'h22, 1'b1, -1, -1, rise);
        chk("overrun_valid", valid, 1);
        chk("overrun_data", rx_data, 8'h22);
        rd = 1'b1; step(); rd = 1'b0;
        chk("overrun_rd", valid, 0);
        // rd coincident with completion: new byte wins
        rx_frame(8'h33, 1'b1, 96, 97, rise);
        chk("rd_collide_valid", valid, 1);
        chk("rd_collide_data", rx_data, 8'h33);
        // reset during a TX frame and an RX frame
        wr = 1'b1; tx_data = 8'h00; step(); wr = 1'b0;
        rx_drv = 1'b0;
        repeat (25) step();
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_tx", tx, 0);
        resetq = 1'b1;
        #2;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_valid", valid, 0);
        chk("async_reset_data", rx_data, 8'h00);
        rx_drv = 1'b1;
        repeat (3) step();
        resetq = 1'b0;
        repeat (5) step();
        // loopback
        loop = 1'b1;
        wr = 1'b1; tx_data = 8'hC3; step(); wr = 1'b0;
        n = 0;
        while (!valid && n < 150) begin
            step();
            n++;
        end
        chk("loop_valid", valid, 1);
        chk("loop_data", rx_data, 8'hC3);
        repeat (5) step();
        chk("loop_tx_done", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
